// File: rtl/alu_control_seq_if.sv
// Port bundle for alu_control_seq: decode inputs, registered control and
// the mult/div sequencer outputs.
interface alu_control_seq_if;
  // Flow control: an instruction on aluop/funct is taken at a rising edge
  // only when en=1 and stall=0. en acts as valid, ~stall as ready. With
  // stall=1 the source must hold aluop/funct unchanged until it is taken.
  logic       en;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic [3:0] aluctl;
  logic       stall;
  logic       md_start;
  logic [1:0] md_op;
  logic       md_busy;
  logic       hilo_we;
  logic [1:0] dbg_state;

  modport master (
    output en, aluop, funct,
    input  aluctl, stall, md_start, md_op, md_busy, hilo_we, dbg_state
  );

  modport slave (
    input  en, aluop, funct,
    output aluctl, stall, md_start, md_op, md_busy, hilo_we, dbg_state
  );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a counter-based mult/div sequencer.
// The sequencer is built only when ALU_CONTROL_SEQ_MULDIV_EN is defined.
module alu_control_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst_n,
  alu_control_seq_if.slave bus
);

  logic [3:0] dec_aluctl;
  logic [3:0] aluctl_d, aluctl_q;
  logic       stall;
  logic       capture;

  always_comb begin
    dec_aluctl = 4'd0;
    case (bus.aluop)
      2'd0: dec_aluctl = 4'd2;
      2'd1: dec_aluctl = 4'd6;
      2'd3: dec_aluctl = 4'd2;
      default: begin
        // Full six-bit match; 0x18-0x1B and unknown codes fall to 0.
        case (bus.funct)
          6'h20, 6'h21:               dec_aluctl = 4'd2;
          6'h22, 6'h23:               dec_aluctl = 4'd6;
          6'h24:                      dec_aluctl = 4'd0;
          6'h25:                      dec_aluctl = 4'd1;
          6'h26:                      dec_aluctl = 4'd13;
          6'h27:                      dec_aluctl = 4'd12;
          6'h2A:                      dec_aluctl = 4'd7;
          6'h2B:                      dec_aluctl = 4'd8;
          6'h10, 6'h11, 6'h12, 6'h13: dec_aluctl = 4'd2;
          default:                    dec_aluctl = 4'd0;
        endcase
      end
    endcase
  end

  assign capture  = bus.en & ~stall;
  assign aluctl_d = capture ? dec_aluctl : aluctl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluctl_q <= 4'd2;
    end else begin
      aluctl_q <= aluctl_d;
    end
  end

  assign bus.aluctl = aluctl_q;

`ifdef ALU_CONTROL_SEQ_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [1:0]       md_op_d, md_op_q;
  logic             md_start_d, md_start_q;
  logic             hilo_we_d, hilo_we_q;
  logic             is_md;
  logic             is_hilo;
  logic             busy;

  assign is_md   = (bus.aluop == 2'd2) && (bus.funct[5:2] == 4'b0110);
  assign is_hilo = (bus.aluop == 2'd2) && (bus.funct[5:2] == 4'b0100);
  assign busy    = (state_q != S_IDLE);
  // DONE still stalls, so a held dependent op waits until HI/LO is written.
  assign stall   = busy & (is_md | is_hilo);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_op_d    = md_op_q;
    md_start_d = 1'b0;
    hilo_we_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (capture && is_md) begin
          state_d    = S_RUN;
          md_op_d    = bus.funct[1:0];
          cnt_d      = bus.funct[1] ? DIV_LAST : MUL_LAST;
          md_start_d = 1'b1;
        end
      end
      S_RUN: begin
        // Counts regardless of en: the mult/div unit is not pipeline-gated.
        if (cnt_q == '0) begin
          state_d   = S_DONE;
          hilo_we_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      md_op_q    <= 2'd0;
      md_start_q <= 1'b0;
      hilo_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_op_q    <= md_op_d;
      md_start_q <= md_start_d;
      hilo_we_q  <= hilo_we_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.md_start  = md_start_q;
  assign bus.md_op     = md_op_q;
  assign bus.md_busy   = busy;
  assign bus.hilo_we   = hilo_we_q;
  assign bus.dbg_state = state_q;
`else
  // Sequencer absent: sizing parameters are referenced only to keep them alive.
  logic unused_cfg;
  assign unused_cfg = (MUL_CYCLES + DIV_CYCLES + CNT_W) > 0;

  assign stall         = 1'b0;
  assign bus.stall     = 1'b0;
  assign bus.md_start  = 1'b0;
  assign bus.md_op     = 2'd0;
  assign bus.md_busy   = 1'b0;
  assign bus.hilo_we   = 1'b0;
  assign bus.dbg_state = 2'd0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: decode table, mult/div timing sequences and a
// randomized run against an edge-count reference model.
module tb_alu_control_seq;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
`ifdef ALU_CONTROL_SEQ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_control_seq_if bus();

  alu_control_seq #(
    .MUL_CYCLES(MUL_LAT),
    .DIV_CYCLES(DIV_LAT),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];
  int         edge_no = 0;
  int         acc_edge = -1000;
  int         acc_lat = 0;
  logic [1:0] exp_md_op = 2'd0;
  logic [3:0] exp_aluctl = 4'd2;
  logic       last_stall = 1'b0;

  typedef struct {
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [1:0] aluop, input logic [5:0] funct);
    if (aluop == 2'd1) return 4'd6;
    if (aluop != 2'd2) return 4'd2;
    if (funct == 6'h20 || funct == 6'h21) return 4'd2;
    if (funct == 6'h22 || funct == 6'h23) return 4'd6;
    if (funct == 6'h25) return 4'd1;
    if (funct == 6'h26) return 4'd13;
    if (funct == 6'h27) return 4'd12;
    if (funct == 6'h2A) return 4'd7;
    if (funct == 6'h2B) return 4'd8;
    if (funct >= 6'h10 && funct <= 6'h13) return 4'd2;
    return 4'd0;
  endfunction

  function automatic bit is_md(input logic [1:0] aluop, input logic [5:0] funct);
    return aluop == 2'd2 && funct >= 6'h18 && funct <= 6'h1B;
  endfunction

  function automatic bit is_hilo(input logic [1:0] aluop, input logic [5:0] funct);
    return aluop == 2'd2 && funct >= 6'h10 && funct <= 6'h13;
  endfunction

  // Busy after edge e means e lies in [accept edge, accept edge + LAT].
  function automatic bit m_busy();
    return MD_EN && edge_no >= acc_edge && edge_no <= acc_edge + acc_lat;
  endfunction

  function automatic void model_reset();
    acc_edge   = -1000;
    acc_lat    = 0;
    exp_md_op  = 2'd0;
    exp_aluctl = 4'd2;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle_check(input logic en, input logic [1:0] aluop, input logic [5:0] funct);
    logic exp_stall;
    logic cap;
    @(negedge clk);
    bus.en    = en;
    bus.aluop = aluop;
    bus.funct = funct;
    #1;
    exp_stall  = m_busy() && (is_md(aluop, funct) || is_hilo(aluop, funct));
    last_stall = bus.stall;
    check("stall", bus.stall, exp_stall);
    cap = en && !exp_stall;
    @(posedge clk);
    edge_no++;
    if (cap) begin
      exp_aluctl = ref_alu(aluop, funct);
      if (MD_EN && is_md(aluop, funct)) begin
        acc_edge  = edge_no;
        acc_lat   = funct[1] ? DIV_LAT : MUL_LAT;
        exp_md_op = funct[1:0];
      end
    end
    exp_q.push_back(exp_aluctl);
    #1;
    check("aluctl", bus.aluctl, exp_q.pop_front());
    check("md_busy", bus.md_busy, m_busy());
    check("md_start", bus.md_start, MD_EN && edge_no == acc_edge);
    check("hilo_we", bus.hilo_we, MD_EN && edge_no == acc_edge + acc_lat);
    check("md_op", bus.md_op, exp_md_op);
  endtask

  task automatic drain();
    repeat (DIV_LAT + 4) cycle_check(1'b1, 2'd0, 6'h00);
  endtask

  // ---------------- test ----------------
  initial begin
    int start;
    int rel;
    int n_st;
    logic seen;
    logic [5:0] f;
    logic [5:0] pick[13];

    tbl[0]  = '{2'd2, 6'h20, 4'd2};
    tbl[1]  = '{2'd2, 6'h22, 4'd6};
    tbl[2]  = '{2'd2, 6'h24, 4'd0};
    tbl[3]  = '{2'd2, 6'h25, 4'd1};
    tbl[4]  = '{2'd2, 6'h26, 4'd13};
    tbl[5]  = '{2'd2, 6'h27, 4'd12};
    tbl[6]  = '{2'd2, 6'h2A, 4'd7};
    tbl[7]  = '{2'd2, 6'h2B, 4'd8};
    tbl[8]  = '{2'd2, 6'h3F, 4'd0};
    tbl[9]  = '{2'd1, 6'h3F, 4'd6};
    tbl[10] = '{2'd0, 6'h22, 4'd2};
    tbl[11] = '{2'd2, 6'h23, 4'd6};
    tbl[12] = '{2'd3, 6'h24, 4'd2};
    tbl[13] = '{2'd2, 6'h00, 4'd0};
    tbl[14] = '{2'd2, 6'h10, 4'd2};
    tbl[15] = '{2'd2, 6'h08, 4'd0};
    tbl[16] = '{2'd2, 6'h21, 4'd2};
    tbl[17] = '{2'd2, 6'h13, 4'd2};

    bus.en = 1'b0; bus.aluop = 2'd0; bus.funct = 6'h00;
    #12;
    check("rst_aluctl", bus.aluctl, 4'd2);
    check("rst_md_busy", bus.md_busy, 1'b0);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_md_start", bus.md_start, 1'b0);
    check("rst_hilo_we", bus.hilo_we, 1'b0);
    check("rst_md_op", bus.md_op, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cycle_check(1'b1, tbl[i].aluop, tbl[i].funct);
      check("tbl_aluctl", bus.aluctl, tbl[i].exp);
    end
    // en=0 must hold the previous value
    cycle_check(1'b0, 2'd1, 6'h00);
    check("en0_hold", bus.aluctl, 4'd2);

`ifdef ALU_CONTROL_SEQ_MULDIV_EN
    // MULT timing
    cycle_check(1'b1, 2'd2, 6'h18);
    start = edge_no;
    check("mult_start", bus.md_start, 1'b1);
    check("mult_op", bus.md_op, 2'd0);
    rel = -1; n_st = -1;
    for (int i = 0; i < 8; i++) begin
      cycle_check(1'b1, 2'd0, 6'h00);
      if (bus.hilo_we && rel < 0) rel = edge_no - start;
      if (!bus.md_busy && n_st < 0) n_st = edge_no - start;
    end
    check("mult_hilo_edge", rel, MUL_LAT);
    check("mult_idle_edge", n_st, MUL_LAT + 1);

    // DIVU then dependent MFLO held
    cycle_check(1'b1, 2'd2, 6'h24);
    cycle_check(1'b1, 2'd2, 6'h1B);
    check("divu_op", bus.md_op, 2'd3);
    n_st = 0;
    for (int i = 0; i < 40; i++) begin
      cycle_check(1'b1, 2'd2, 6'h12);
      if (!last_stall) break;
      n_st++;
      check("divu_aluctl_held", bus.aluctl, 4'd0);
    end
    check("divu_stall_cycles", n_st, DIV_LAT + 1);
    check("mflo_aluctl", bus.aluctl, 4'd2);

    // ADD during DIV, with en toggling
    cycle_check(1'b1, 2'd2, 6'h1A);
    start = edge_no;
    cycle_check(1'b1, 2'd2, 6'h20);
    check("add_in_div_aluctl", bus.aluctl, 4'd2);
    rel = -1;
    for (int i = 0; i < 40; i++) begin
      cycle_check(logic'(i % 3 != 0), 2'd2, 6'h22);
      if (bus.hilo_we && rel < 0) rel = edge_no - start;
    end
    check("div_hilo_edge", rel, DIV_LAT);

    // back-to-back MULT held while stalled
    cycle_check(1'b1, 2'd2, 6'h18);
    start = edge_no;
    rel = -1;
    for (int i = 0; i < 20; i++) begin
      cycle_check(1'b1, 2'd2, 6'h18);
      if (bus.md_start) begin
        rel = edge_no - start;
        break;
      end
    end
    check("b2b_accept_edge", rel, MUL_LAT + 2);
    drain();
`else
    cycle_check(1'b1, 2'd2, 6'h18);
    check("nomd_aluctl", bus.aluctl, 4'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle_check(1'b1, 2'd2, (i % 2 == 0) ? 6'h12 : 6'h1B);
      seen = seen | bus.md_start | bus.hilo_we | bus.md_busy | last_stall;
    end
    check("nomd_quiet", seen, 1'b0);
`endif

    // randomized phase
    pick = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13,
             6'h20, 6'h22, 6'h25, 6'h2A, 6'h2B};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) f = 6'($urandom_range(0, 63));
      else f = pick[$urandom_range(0, 12)];
      cycle_check(logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), f);
    end
    drain();

`ifdef ALU_CONTROL_SEQ_MULDIV_EN
    // reset in the middle of a MULT
    cycle_check(1'b1, 2'd2, 6'h24);
    cycle_check(1'b1, 2'd2, 6'h18);
    cycle_check(1'b1, 2'd2, 6'h18);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("abort_busy", bus.md_busy, 1'b0);
    check("abort_stall", bus.stall, 1'b0);
    check("abort_aluctl", bus.aluctl, 4'd2);
    check("abort_hilo_we", bus.hilo_we, 1'b0);
    bus.en = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      seen = seen | bus.hilo_we;
    end
    check("abort_no_hilo", seen, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle_check(1'b1, 2'd0, 6'h00);
      check("post_abort_hilo", bus.hilo_we, 1'b0);
    end
    cycle_check(1'b1, 2'd2, 6'h19);
    start = edge_no;
    check("multu_op", bus.md_op, 2'd1);
    rel = -1;
    for (int i = 0; i < 8; i++) begin
      cycle_check(1'b1, 2'd0, 6'h00);
      if (bus.hilo_we && rel < 0) rel = edge_no - start;
    end
    check("multu_hilo_edge", rel, MUL_LAT);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
